// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: sequential advance, branch and
// flush redirects, a one-entry pending-branch buffer for stalls, and status outputs.
module pc_gen #(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
    parameter int unsigned          INST_BYTES = 4,
    parameter int unsigned          STALL_W    = 6,
    parameter int unsigned          CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                branch_flag_i,
    input  logic [ADDR_W-1:0]   branch_target_address_i,
    input  logic                flush_i,
    input  logic [ADDR_W-1:0]   flush_pc_i,
    output logic [ADDR_W-1:0]   pc,
    output logic                ce,
    output logic                redirect_o,
    output logic                misalign_o,
    output logic                pend_valid_o,
    output logic [CNT_W-1:0]    fetch_cnt_o
);

    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

    logic              ce_q, ce_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              redirect_q, redirect_d;
    logic              misalign_q, misalign_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic              advance;

    assign advance = ~stall[0];

    generate
        if (STALL_W > 1) begin : g_unused_stall
            logic unused_stall;
            assign unused_stall = ^stall[STALL_W-1:1];
        end
    endgenerate

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        ce_d         = ce_q;
        pc_d         = pc_q;
        redirect_d   = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        fetch_cnt_d  = fetch_cnt_q;

        if (!ce_q) begin
            ce_d = 1'b1;
        end else begin
            if (advance) begin
                fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
            end
            // Flush beats everything, even a stall; a branch seen under stall is parked.
            if (flush_i) begin
                pc_d         = flush_pc_i;
                pend_valid_d = 1'b0;
                redirect_d   = 1'b1;
            end else if (branch_flag_i && advance) begin
                pc_d         = branch_target_address_i;
                pend_valid_d = 1'b0;
                redirect_d   = 1'b1;
            end else if (branch_flag_i) begin
                pend_addr_d  = branch_target_address_i;
                pend_valid_d = 1'b1;
            end else if (pend_valid_q && advance) begin
                pc_d         = pend_addr_q;
                pend_valid_d = 1'b0;
                redirect_d   = 1'b1;
            end else if (advance) begin
                pc_d = pc_q + PC_INC;
            end
        end

        misalign_d = (pc_d & ALIGN_MASK) != '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ce_q         <= 1'b0;
            pc_q         <= RESET_PC;
            redirect_q   <= 1'b0;
            misalign_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            fetch_cnt_q  <= '0;
        end else begin
            ce_q         <= ce_d;
            pc_q         <= pc_d;
            redirect_q   <= redirect_d;
            misalign_q   <= misalign_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign pc           = pc_q;
    assign ce           = ce_q;
    assign redirect_o   = redirect_q;
    assign misalign_o   = misalign_q;
    assign pend_valid_o = pend_valid_q;
    assign fetch_cnt_o  = fetch_cnt_q;

endmodule
